fetch_queue: RTL and testbench

Parametrised instruction fetch stage with a prefetch queue. It sits between the instruction memory (synchronous read, fixed one-cycle latency) and decode. It generates sequential PCs, redirects on a taken branch, flushes wrong-path work, and presents `{pc, instr}` pairs to decode over a valid/ready handshake so that decode stalls no longer freeze fetch.

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : sequential PC generator + prefetch queue feeding decode.
//   Optional FETCH_QUEUE_PERF_EN adds perf_fetched / perf_flushed.  Rev 1.0
// ============================================================================
module fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic              push;
  logic              pop;
  logic [PTR_W+1:0]  occupancy;

  // Reserve a slot for the outstanding request so a response never overflows.
  assign occupancy = {1'b0, count_q} + {{(PTR_W + 1){1'b0}}, inflight_q};
  assign imem_req  = !rst && !redirect && (occupancy < (PTR_W + 2)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      // Wrong-path work: queued entries not popped this cycle, plus the outstanding request.
      if (redirect) begin
        perf_flushed_q <= perf_flushed_q + 32'(count_q) - 32'(pop) + 32'(inflight_q);
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  // Counters are compiled out; the fetch path is unaffected.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed + random stimulus against a queue-level reference.
//   Rev 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
  logic [31:0] perf_fetched, perf_flushed;

  logic        rst2, redirect2, ready2;
  logic [7:0]  rpc2, addr2, pc2;
  logic        req2, valid2;
  logic [31:0] rdata2, instr2;
  logic [31:0] pf2_fetched, pf2_flushed;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(8'h0)) dut2 (
    .clk(clk), .rst(rst2), .redirect(redirect2), .redirect_pc(rpc2),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .out_valid(valid2), .out_ready(ready2), .out_pc(pc2), .out_instr(instr2)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(pf2_fetched), .perf_flushed(pf2_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  // One-cycle synchronous instruction memories; garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  always @(posedge clk) rdata2     <= req2 ? mem_word({24'h0, addr2}) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: expected fetch PC, list of queued PCs, outstanding request.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_fetched, m_flushed;
  logic [31:0] delivered[$];
  logic [7:0]  got2[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_q.delete(); m_infl = 1'b0; m_ipc = 32'h0;
    m_fetched = 32'h0; m_flushed = 32'h0;
  endtask

  // Apply inputs for one cycle, compare outputs, advance the reference.
  task automatic cycle(input logic r, input logic rd, input logic rdy, input logic [31:0] rpc);
    logic exp_req, pop_m;
    rst = r; redirect = rd; out_ready = rdy; redirect_pc = rpc;
    #1;
    exp_req = !r && !rd && (m_q.size() + int'(m_infl) < DEPTH);
    pop_m   = (m_q.size() != 0) && rdy;
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0]);
      check("out_instr", out_instr, mem_word(m_q[0]));
    end
`ifdef FETCH_QUEUE_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
`endif
    if (out_valid && rdy) delivered.push_back(out_pc);
    if (r) begin
      model_reset();
    end else if (rd) begin
      if (pop_m) m_fetched++;
      m_flushed = m_flushed + 32'(m_q.size()) - 32'(pop_m) + 32'(m_infl);
      m_q.delete();
      m_infl = 1'b0;
      m_pc = rpc;
    end else begin
      if (m_infl) check("overflow", m_q.size() < DEPTH, 1'b1);
      if (pop_m) begin
        void'(m_q.pop_front());
        m_fetched++;
      end
      if (m_infl) m_q.push_back(m_ipc);
      if (exp_req) begin
        m_ipc = m_pc; m_infl = 1'b1; m_pc = m_pc + 32'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle2(input logic r, input logic rd, input logic rdy, input logic [7:0] rpc);
    rst2 = r; redirect2 = rd; ready2 = rdy; rpc2 = rpc;
    #1;
    if (valid2 && rdy) begin
      got2.push_back(pc2);
      check("wrap_instr", instr2, mem_word({24'h0, pc2}));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    logic [7:0]  wrap_exp[4];
    rst = 1'b1; redirect = 1'b0; out_ready = 1'b0; redirect_pc = '0;
    rst2 = 1'b1; redirect2 = 1'b0; ready2 = 1'b0; rpc2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    cycle(1, 0, 0, 0);

    // Sequential fetch: PCs 0,1,2.. on consecutive cycles from R+2
    delivered.delete();
    repeat (12) cycle(0, 0, 1, 0);
    check("seq_count", delivered.size(), 10);
    for (int k = 0; k < delivered.size() && k < 10; k++) check("seq_pc", delivered[k], k);

    // Backpressure from reset
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    check("bp_req", imem_req, 0);
    check("bp_valid", out_valid, 1);
    check("bp_out_pc", out_pc, 0);
    delivered.delete();
    repeat (8) cycle(0, 0, 1, 0);
    check("bp_count", delivered.size() >= 5, 1);
    for (int k = 0; k < delivered.size() && k < 5; k++) check("bp_order", delivered[k], k);

    // Redirect flush of a full queue
    repeat (6) cycle(0, 0, 0, 0);
    base = m_flushed;
`ifdef FETCH_QUEUE_PERF_EN
    base = perf_flushed;
`endif
    cycle(0, 1, 0, 32'h40);
    check("flush_n1_valid", out_valid, 0);
`ifdef FETCH_QUEUE_PERF_EN
    check("flush_delta", perf_flushed - base, 4);
`endif
    cycle(0, 0, 0, 0);
    check("flush_n2_valid", out_valid, 0);
    cycle(0, 0, 0, 0);
    check("flush_n3_valid", out_valid, 1);
    check("flush_n3_pc", out_pc, 32'h40);

    // Redirect coinciding with pop and response
    repeat (6) cycle(0, 0, 1, 0);
    base = m_fetched;
`ifdef FETCH_QUEUE_PERF_EN
    base = perf_fetched;
`endif
    cycle(0, 1, 1, 32'h80);
`ifdef FETCH_QUEUE_PERF_EN
    check("rpop_fetched", perf_fetched - base, 1);
`endif
    delivered.delete();
    repeat (6) cycle(0, 0, 1, 0);
    check("rpop_count", delivered.size() != 0, 1);
    if (delivered.size() != 0) check("rpop_first_pc", delivered[0], 32'h80);

    // Reset mid-stream with 3 queued entries and a request in flight
    cycle(0, 1, 0, 32'h200);
    for (int i = 0; i < 20 && !(m_q.size() == 3 && m_infl); i++) cycle(0, 0, 0, 0);
    check("mid_valid_before", out_valid, 1);
    cycle(1, 0, 0, 0);
    check("mid_valid", out_valid, 0);
    check("mid_req", imem_req, 0);
    check("mid_out_pc", out_pc, 0);
    delivered.delete();
    repeat (4) cycle(0, 0, 1, 0);
    check("mid_count", delivered.size() != 0, 1);
    if (delivered.size() != 0) check("mid_first_pc", delivered[0], 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom);
    end

    // PC wrap on the 8-bit, step-4 instance
    cycle2(1, 0, 0, 8'h0);
    cycle2(1, 0, 0, 8'h0);
    cycle2(0, 1, 0, 8'hF8);
    for (int i = 0; i < 20 && got2.size() < 4; i++) cycle2(0, 0, 1, 8'h0);
    check("wrap_count", got2.size() >= 4, 1);
    wrap_exp[0] = 8'hF8; wrap_exp[1] = 8'hFC; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h04;
    for (int k = 0; k < got2.size() && k < 4; k++) check("wrap_pc", got2[k], wrap_exp[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
